// File: rtl/banked_reg_file.sv
// 16-entry register file, r13/r14 banked per mode, per-register busy scoreboard.
// Optional write-through forwarding when REG_FILE_BYPASS_EN is defined.
module banked_reg_file #(
  parameter int             N         = 32,
  parameter int             NUM_BANKS = 4,
  parameter logic [N-1:0]   R15_RESET = '0,
  localparam int            BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BANK_W-1:0] mode_i,
  input  logic [3:0]        address1_i,
  input  logic [3:0]        address2_i,
  input  logic [3:0]        address3_i,
  output logic [N-1:0]      output1_o,
  output logic [N-1:0]      output2_o,
  output logic [N-1:0]      output3_o,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic              busy3_o,
  input  logic [3:0]        address_write1_i,
  input  logic [N-1:0]      write_data1_i,
  input  logic              write_enable1_i,
  input  logic [3:0]        address_write2_i,
  input  logic [N-1:0]      write_data2_i,
  input  logic              write_enable2_i,
  input  logic              reserve_i,
  input  logic [3:0]        reserve_addr_i,
  input  logic [N-1:0]      r15_i,
  output logic [N-1:0]      r15_o
);
  // Flat physical map: r0..r12, r13 banks, r14 banks, r15 last.
  localparam int P       = 14 + 2*NUM_BANKS;
  localparam int PW      = $clog2(P);
  localparam int R15_IDX = P - 1;

  function automatic logic [PW-1:0] phys(input logic [3:0] a, input logic [BANK_W-1:0] b);
    case (a)
      4'd13:   return PW'(13 + int'(b));
      4'd14:   return PW'(13 + NUM_BANKS + int'(b));
      4'd15:   return PW'(R15_IDX);
      default: return PW'(a);
    endcase
  endfunction

  logic [N-1:0]      r_phys [P];
  logic [P-1:0]      r_busy;

  logic [BANK_W-1:0] w_bank;
  logic [PW-1:0]     w_pw1, w_pw2, w_prsv;
  logic [N-1:0]      w_nxt [P];
  logic [P-1:0]      w_wr, w_rsv;
  logic [2:0][3:0]   w_raddr;
  logic [2:0][PW-1:0] w_pr;
  logic [2:0][N-1:0] w_rdata;
  logic [2:0]        w_rbusy;

  assign w_bank  = (int'(mode_i) < NUM_BANKS) ? mode_i : '0;
  assign w_pw1   = phys(address_write1_i, w_bank);
  assign w_pw2   = phys(address_write2_i, w_bank);
  assign w_prsv  = phys(reserve_addr_i, w_bank);
  assign w_raddr = {address3_i, address2_i, address1_i};

  // Next value per physical register: port 2 > port 1 > hold (or r15_i for PC).
  always_comb begin
    for (int p = 0; p < P; p++) begin
      w_wr[p]  = (write_enable1_i && w_pw1 == PW'(p)) || (write_enable2_i && w_pw2 == PW'(p));
      w_rsv[p] = reserve_i && (reserve_addr_i != 4'd15) && (w_prsv == PW'(p));
      if (write_enable2_i && w_pw2 == PW'(p))      w_nxt[p] = write_data2_i;
      else if (write_enable1_i && w_pw1 == PW'(p)) w_nxt[p] = write_data1_i;
      else if (p == R15_IDX)                       w_nxt[p] = r15_i;
      else                                         w_nxt[p] = r_phys[p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < P; p++) r_phys[p] <= (p == R15_IDX) ? R15_RESET : '0;
      r_busy <= '0;
    end else begin
      for (int p = 0; p < P; p++) r_phys[p] <= w_nxt[p];
      // A same-cycle reservation names a new producer, so it beats the clear.
      r_busy <= w_rsv | (r_busy & ~w_wr);
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_pr[k] = phys(w_raddr[k], w_bank);
`ifdef REG_FILE_BYPASS_EN
      w_rdata[k] = w_nxt[w_pr[k]];
      w_rbusy[k] = r_busy[w_pr[k]] & ~(w_wr[w_pr[k]] & ~w_rsv[w_pr[k]]);
`else
      w_rdata[k] = r_phys[w_pr[k]];
      w_rbusy[k] = r_busy[w_pr[k]];
`endif
    end
  end

  assign output1_o = w_rdata[0];
  assign output2_o = w_rdata[1];
  assign output3_o = w_rdata[2];
  assign busy1_o   = w_rbusy[0];
  assign busy2_o   = w_rbusy[1];
  assign busy3_o   = w_rbusy[2];
  assign r15_o     = r_phys[R15_IDX];

endmodule

// File: tb/tb_banked_reg_file.sv
// Randomized bench for banked_reg_file against an architectural-level model.
module tb_banked_reg_file;
  localparam int N  = 32;
  localparam int NB = 3;
  localparam int BW = 2;
  localparam logic [N-1:0] RST15 = 32'h100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] mode_i;
  logic [3:0]    address1_i, address2_i, address3_i;
  logic [N-1:0]  output1_o, output2_o, output3_o;
  logic          busy1_o, busy2_o, busy3_o;
  logic [3:0]    address_write1_i, address_write2_i, reserve_addr_i;
  logic [N-1:0]  write_data1_i, write_data2_i, r15_i, r15_o;
  logic          write_enable1_i, write_enable2_i, reserve_i;

  banked_reg_file #(.N(N), .NUM_BANKS(NB), .R15_RESET(RST15)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
    .address1_i(address1_i), .address2_i(address2_i), .address3_i(address3_i),
    .output1_o(output1_o), .output2_o(output2_o), .output3_o(output3_o),
    .busy1_o(busy1_o), .busy2_o(busy2_o), .busy3_o(busy3_o),
    .address_write1_i(address_write1_i), .write_data1_i(write_data1_i),
    .write_enable1_i(write_enable1_i),
    .address_write2_i(address_write2_i), .write_data2_i(write_data2_i),
    .write_enable2_i(write_enable2_i),
    .reserve_i(reserve_i), .reserve_addr_i(reserve_addr_i),
    .r15_i(r15_i), .r15_o(r15_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural model: plain registers, banked copies, busy flags.
  logic [N-1:0] m_lo [13];
  logic [N-1:0] m_b13 [NB];
  logic [N-1:0] m_b14 [NB];
  logic [N-1:0] m_r15;
  bit           m_bl [13];
  bit           m_bb13 [NB];
  bit           m_bb14 [NB];

  function automatic int bk(input int mode);
    return (mode < NB) ? mode : 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 13; i++) begin m_lo[i] = '0; m_bl[i] = 0; end
    for (int b = 0; b < NB; b++) begin
      m_b13[b] = '0; m_b14[b] = '0; m_bb13[b] = 0; m_bb14[b] = 0;
    end
    m_r15 = RST15;
  endtask

  function automatic logic [N-1:0] m_rd(input int a, input int mode);
    if (a < 13)  return m_lo[a];
    if (a == 13) return m_b13[bk(mode)];
    if (a == 14) return m_b14[bk(mode)];
    return m_r15;
  endfunction

  function automatic bit m_bsy(input int a, input int mode);
    if (a < 13)  return m_bl[a];
    if (a == 13) return m_bb13[bk(mode)];
    if (a == 14) return m_bb14[bk(mode)];
    return 0;
  endfunction

  task automatic m_wr(input int a, input logic [N-1:0] d, input int b);
    if (a < 13)       m_lo[a] = d;
    else if (a == 13) m_b13[b] = d;
    else if (a == 14) m_b14[b] = d;
    else              m_r15 = d;
  endtask

  task automatic m_setb(input int a, input int b, input bit v);
    if (a < 13)       m_bl[a] = v;
    else if (a == 13) m_bb13[b] = v;
    else if (a == 14) m_bb14[b] = v;
  endtask

  // Clock edge: r15_i first, then port 1, then port 2 so later writes win.
  task automatic m_step();
    int b;
    b = bk(int'(mode_i));
    m_r15 = r15_i;
    if (write_enable1_i) m_wr(int'(address_write1_i), write_data1_i, b);
    if (write_enable2_i) m_wr(int'(address_write2_i), write_data2_i, b);
    if (write_enable1_i) m_setb(int'(address_write1_i), b, 0);
    if (write_enable2_i) m_setb(int'(address_write2_i), b, 0);
    if (reserve_i) m_setb(int'(reserve_addr_i), b, 1);
  endtask

  // Within one cycle a single mode applies, so same address means same physical register.
  function automatic logic [N-1:0] exp_rd(input logic [3:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (write_enable2_i && address_write2_i == a) return write_data2_i;
    if (write_enable1_i && address_write1_i == a) return write_data1_i;
    if (a == 4'd15) return r15_i;
`endif
    return m_rd(int'(a), int'(mode_i));
  endfunction

  function automatic logic exp_bsy(input logic [3:0] a);
    bit v;
    v = m_bsy(int'(a), int'(mode_i));
`ifdef REG_FILE_BYPASS_EN
    if (((write_enable1_i && address_write1_i == a) || (write_enable2_i && address_write2_i == a))
        && !(reserve_i && reserve_addr_i == a)) v = 0;
`endif
    return v;
  endfunction

  task automatic check_all();
    chk("rd1", output1_o, exp_rd(address1_i));
    chk("rd2", output2_o, exp_rd(address2_i));
    chk("rd3", output3_o, exp_rd(address3_i));
    chk("bsy1", N'(busy1_o), N'(exp_bsy(address1_i)));
    chk("bsy2", N'(busy2_o), N'(exp_bsy(address2_i)));
    chk("bsy3", N'(busy3_o), N'(exp_bsy(address3_i)));
    chk("r15o", r15_o, m_r15);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle();
    write_enable1_i = 0; write_enable2_i = 0; reserve_i = 0;
    address_write1_i = '0; address_write2_i = '0; reserve_addr_i = '0;
    write_data1_i = '0; write_data2_i = '0;
    r15_i = $urandom;
  endtask

  task automatic rand_in();
    mode_i           = BW'($urandom_range(0, 3));
    address1_i       = 4'($urandom); address2_i = 4'($urandom); address3_i = 4'($urandom);
    address_write1_i = 4'($urandom); address_write2_i = 4'($urandom);
    write_data1_i    = $urandom;     write_data2_i = $urandom;
    write_enable1_i  = 1'($urandom); write_enable2_i = 1'($urandom);
    reserve_i        = ($urandom_range(0, 2) == 0);
    reserve_addr_i   = 4'($urandom);
    r15_i            = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    mode_i = '0; address1_i = 4'd3; address2_i = 4'd15; address3_i = 4'd13;
    idle();
    m_reset();
    @(negedge clk);
    #1;
    chk("rst_r15", r15_o, 32'h100);
    chk("rst_rd1", output1_o, '0);
    chk("rst_rd2", output2_o, 32'h100);
    chk("rst_bsy", N'({busy1_o, busy2_o, busy3_o}), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset state and dual-port same-address priority.
    tick();
    write_enable1_i = 1; address_write1_i = 4'd4; write_data1_i = 32'hAAAA;
    write_enable2_i = 1; address_write2_i = 4'd4; write_data2_i = 32'h5555;
    tick();
    idle(); address1_i = 4'd4;
    #1 chk("wr_pri", output1_o, 32'h5555);
    tick();

    // Port write to r15 beats r15_i.
    write_enable1_i = 1; address_write1_i = 4'd15; write_data1_i = 32'h40; r15_i = 32'h8;
    tick();
    idle();
    #1 chk("r15_wr", r15_o, 32'h40);
    tick();

    // r13 banking, including out-of-range mode folding to bank 0.
    mode_i = 2'd1; write_enable1_i = 1; address_write1_i = 4'd13; write_data1_i = 32'h1111;
    tick();
    mode_i = 2'd0; write_data1_i = 32'h2222;
    tick();
    idle(); address1_i = 4'd13;
    #1 chk("bank0", output1_o, 32'h2222);
    mode_i = 2'd1;
    #1 chk("bank1", output1_o, 32'h1111);
    mode_i = 2'd3;
    #1 chk("bank3", output1_o, 32'h2222);
    tick();

    // Scoreboard: reserve, reserve+write, then clearing write.
    mode_i = 2'd0; address1_i = 4'd7; reserve_i = 1; reserve_addr_i = 4'd7;
    tick();
    idle();
    #1 chk("rsv7", N'(busy1_o), 1);
    reserve_i = 1; reserve_addr_i = 4'd7;
    write_enable2_i = 1; address_write2_i = 4'd7; write_data2_i = 32'h77;
    tick();
    idle();
    #1 chk("rsv_win", N'(busy1_o), 1);
    write_enable1_i = 1; address_write1_i = 4'd7; write_data1_i = 32'h78;
    tick();
    idle();
    #1 chk("clr7", N'(busy1_o), 0);
    tick();

    // Same-cycle visibility of a write.
    write_enable1_i = 1; address_write1_i = 4'd2; write_data1_i = 32'hBEEF; address1_i = 4'd2;
`ifdef REG_FILE_BYPASS_EN
    #1 chk("byp0", output1_o, 32'hBEEF);
`else
    #1 chk("byp0", output1_o, '0);
`endif
    tick();
    idle();
    #1 chk("byp1", output1_o, 32'hBEEF);
    tick();

    // Asynchronous reset in the middle of a cycle.
    write_enable1_i = 1; address_write1_i = 4'd5; write_data1_i = 32'h9;
    reserve_i = 1; reserve_addr_i = 4'd7;
    tick();
    idle(); address1_i = 4'd5; address2_i = 4'd7;
    #1 chk("pre_r5", output1_o, 32'h9);
    chk("pre_b7", N'(busy2_o), 1);
    #1 rst_n = 1'b0;
    #1 chk("arst_r5", output1_o, '0);
    chk("arst_b7", N'(busy2_o), 0);
    chk("arst_r15", r15_o, RST15);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 600; c++) begin
      rand_in();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/banked_reg_file.md
Name: banked_reg_file

Overview:
- Next-generation core register file: 16 architectural registers of width N, three combinational read ports, two write ports, plus the dedicated r15 (PC) update path.
- Adds ARM-style mode banking of r13/r14 across NUM_BANKS processor modes.
- Adds a per-register busy scoreboard that the issue stage uses to stall on pending writebacks.
- Sits between decode/issue (reads, reservations) and writeback (write ports).

Parameters:
- N, 32, data width of every register.
- NUM_BANKS, 4, number of r13/r14 banks; bank 0 = user/system. BANK_W = $clog2(NUM_BANKS), minimum 1.
- R15_RESET, 32'h0000_0000, r15 value after reset (N bits).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mode_i  in  BANK_W  active bank; applies to all reads, writes and reservations this cycle
- address1_i / address2_i / address3_i  in  4  read addresses
- output1_o / output2_o / output3_o  out  N  read data
- busy1_o / busy2_o / busy3_o  out  1  scoreboard bit of the register addressed by the matching read port
- address_write1_i  in  4  write port 1 address
- write_data1_i  in  N  write port 1 data
- write_enable1_i  in  1  write port 1 enable
- address_write2_i  in  4  write port 2 address
- write_data2_i  in  N  write port 2 data
- write_enable2_i  in  1  write port 2 enable
- reserve_i  in  1  mark a register busy (pending writeback)
- reserve_addr_i  in  4  register to reserve
- r15_i  in  N  next PC, written every cycle
- r15_o  out  N  current r15

Behaviour:
- Physical storage:
  - r0–r12 and r15: one copy each.
  - r13 and r14: NUM_BANKS copies each.
  - Address 13/14 resolves to bank mode_i. mode_i >= NUM_BANKS resolves to bank 0.
- Reset (async, rst_n=0): all registers 0, r15 = R15_RESET, all busy bits 0. Outputs therefore read 0, except for address 15 and r15_o, which read R15_RESET. Deassertion takes effect at the next rising edge.
- Reads: combinational from registered state through bank resolution. A write becomes visible the cycle after its edge.
- Write priority per physical register at each edge: port 2 > port 1 > r15_i.
  - r15 always loads r15_i unless a port writes address 15.
  - Both ports targeting the same address: port 2 data wins.
- Writes to 13/14 land in the bank selected by mode_i in that cycle. Other banks are untouched.
- Scoreboard, one busy bit per physical register:
  - Set at the edge when reserve_i=1 for the resolved reserve_addr_i.
  - Cleared at the edge when any enabled write port targets that physical register.
  - Reserve and write to the same physical register in the same cycle: reserve wins, bit ends 1 (new producer).
  - reserve_addr_i=15 is ignored; r15's busy bit is constant 0.
  - Reserving an already-busy register keeps it busy; no counting.
- busyK_o reflects the registered busy bit of the resolved addressK_i.
- Mode change: takes effect combinationally on reads and busy outputs. Pending busy bits of the inactive banks are retained and still clear on later writes that target them.
- Reset mid-operation discards all pending writes and reservations.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through forwarding.
  - A read whose resolved physical register is being written this cycle returns the write data; port 2 has priority over port 1.
  - Address 15 returns the effective next r15 value.
  - busyK_o is forced 0 when an enabled write targets the resolved register, unless reserve_i targets it in the same cycle.
  - Read latency from write is 0 cycles.
- Undefined: reads and busy outputs come from registered state only; latency 1 cycle.

Test Plan:
- Reset with R15_RESET=32'h100, then release -> r15_o=32'h100, output1_o for addr 3 = 0, all busyK_o = 0.
- Same edge: port1 writes r4=32'hAAAA and port2 writes r4=32'h5555 -> next cycle addr 4 reads 32'h5555. Port1 writes r15=32'h40 with r15_i=32'h8 -> r15_o=32'h40.
- mode_i=1, write r13=32'h1111; then mode_i=0, write r13=32'h2222 -> reads 32'h2222 in mode 0, 32'h1111 in mode 1. With NUM_BANKS=3, mode_i=3 reads 32'h2222.
- Reserve r7 -> busy1_o=1 for addr 7 next cycle. Reserve r7 and port2 writes r7 in the same cycle -> busy stays 1. Later port1 write r7 -> busy 0.
- Assert rst_n=0 asynchronously mid-cycle after busy r7 and r5=32'h9 -> outputs and busy drop immediately to 0, r15_o=R15_RESET.
- With REG_FILE_BYPASS_EN: port1 writes r2=32'hBEEF while address1_i=2 -> output1_o=32'hBEEF in the same cycle. Without the macro -> 32'hBEEF appears one cycle later.
